wb_term_resp: RTL

Parametrised Wishbone pipelined default slave, the successor to the fixed always-ack terminator. It sits on unmapped address decode holes and on unused interconnect ports. Every accepted request gets exactly one response after a programmable latency: an ack carrying a fill word, or a bus error. The block also limits outstanding requests with stall, and logs the first faulting access plus a saturating fault count for software and debug.

---
 rtl/wb_term_pkg.sv | 21 ++
 rtl/if_wb.sv | 23 ++
 rtl/wb_resp_pipe.sv | 35 +++
 rtl/wb_term_resp.sv | 125 ++++++++++++
 4 files changed

// File: rtl/wb_term_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_term_pkg: shared types and helpers for the Wishbone terminating slave
// Rev 1.0
// ----------------------------------------------------------------------------
package wb_term_pkg;

  typedef enum logic {
    RESP_ACK = 1'b0,
    RESP_ERR = 1'b1
  } resp_mode_t;

  localparam int DEF_CNT_W = 16;

  // Width needed to hold the values 0..max_out inclusive
  function automatic int out_cnt_w(input int max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_wb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// if_wb: Wishbone pipelined bus; dat_m flows master->slave, dat_s slave->master
// Rev 1.0
// ----------------------------------------------------------------------------
interface if_wb #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic            cyc;
  logic            stb;
  logic            we;
  logic [DW/8-1:0] sel;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_m;
  logic [DW-1:0]   dat_s;
  logic            ack;
  logic            stall;

  modport master (output cyc, stb, we, sel, adr, dat_m, input dat_s, ack, stall);
  modport slave  (input cyc, stb, we, sel, adr, dat_m, output dat_s, ack, stall);
endinterface
`default_nettype wire

// File: rtl/wb_resp_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_resp_pipe: LATENCY-deep valid delay line with synchronous flush
// Rev 1.0
// ----------------------------------------------------------------------------
module wb_resp_pipe #(
  parameter int LATENCY = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic in_i,
  output logic due_o
);

  logic [LATENCY-1:0] stage_q;
  logic [LATENCY-1:0] stage_d;

  generate
    if (LATENCY == 1) begin : g_single
      always_comb stage_d = flush_i ? 1'b0 : in_i;
    end else begin : g_multi
      always_comb stage_d = flush_i ? '0 : {stage_q[LATENCY-2:0], in_i};
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign due_o = stage_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/wb_term_resp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// wb_term_resp: Wishbone pipelined default slave with latency, stall and fault log
// Rev 1.0
// ----------------------------------------------------------------------------
module wb_term_resp
  import wb_term_pkg::*;
#(
  parameter int              DW      = 32,
  parameter int              AW      = 32,
  parameter int              LATENCY = 1,
  parameter int              MAX_OUT = 2,
  parameter resp_mode_t      MODE    = RESP_ACK,
  parameter logic [DW-1:0]   FILL    = '0,
  parameter int              CNT_W   = DEF_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  if_wb.slave               bus,
  output logic              err_o,
  input  logic              clr_i,
  output logic              fault_valid_o,
  output logic [AW-1:0]     fault_adr_o,
  output logic              fault_we_o,
  output logic [DW/8-1:0]   fault_sel_o,
  output logic [CNT_W-1:0]  fault_cnt_o
);

  localparam int OW = out_cnt_w(MAX_OUT);

  logic [OW-1:0]    out_q, out_d;
  logic             fault_valid_q, fault_valid_d;
  logic [AW-1:0]    fault_adr_q, fault_adr_d;
  logic             fault_we_q, fault_we_d;
  logic [DW/8-1:0]  fault_sel_q, fault_sel_d;
  logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
  logic [CNT_W-1:0] cnt_base;

  logic stall;
  logic accept;
  logic due;
  logic resp;
  logic unused_wdata;

  assign stall  = (out_q == OW'(MAX_OUT));
  assign accept = bus.cyc & bus.stb & ~stall;

  // Dropping cyc kills every in-flight response, including one due this cycle
  assign resp   = due & bus.cyc;

  wb_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (~bus.cyc),
    .in_i    (accept),
    .due_o   (due)
  );

  assign bus.stall    = stall;
  assign bus.ack      = resp & (MODE == RESP_ACK);
  assign err_o        = resp & (MODE == RESP_ERR);
  assign bus.dat_s    = (resp && MODE == RESP_ACK) ? FILL : '0;
  assign unused_wdata = ^bus.dat_m;

  always_comb begin
    out_d = out_q;
    if (!bus.cyc) begin
      out_d = '0;
    end else if (accept && !resp) begin
      out_d = out_q + OW'(1);
    end else if (!accept && resp) begin
      out_d = out_q - OW'(1);
    end
  end

  always_comb begin
    fault_valid_d = fault_valid_q;
    fault_adr_d   = fault_adr_q;
    fault_we_d    = fault_we_q;
    fault_sel_d   = fault_sel_q;
    fault_cnt_d   = fault_cnt_q;
    cnt_base      = clr_i ? '0 : fault_cnt_q;
    // An accept coinciding with clr restarts the log with this access
    if (accept) begin
      fault_cnt_d   = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
      fault_valid_d = 1'b1;
      if (!fault_valid_q || clr_i) begin
        fault_adr_d = bus.adr;
        fault_we_d  = bus.we;
        fault_sel_d = bus.sel;
      end
    end else if (clr_i) begin
      fault_valid_d = 1'b0;
      fault_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q         <= '0;
      fault_valid_q <= 1'b0;
      fault_adr_q   <= '0;
      fault_we_q    <= 1'b0;
      fault_sel_q   <= '0;
      fault_cnt_q   <= '0;
    end else begin
      out_q         <= out_d;
      fault_valid_q <= fault_valid_d;
      fault_adr_q   <= fault_adr_d;
      fault_we_q    <= fault_we_d;
      fault_sel_q   <= fault_sel_d;
      fault_cnt_q   <= fault_cnt_d;
    end
  end

  assign fault_valid_o = fault_valid_q;
  assign fault_adr_o   = fault_adr_q;
  assign fault_we_o    = fault_we_q;
  assign fault_sel_o   = fault_sel_q;
  assign fault_cnt_o   = fault_cnt_q;

endmodule
`default_nettype wire
